// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone slave port among NUM_MASTERS requesters.
// The grant is held for the whole cyc. A watchdog turns a stalled slave into an err.
module wb_arbiter_rr #(
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_MASTERS*32-1:0] m_adr_i,
   input  logic [NUM_MASTERS*32-1:0] m_dat_i,
   output logic [NUM_MASTERS*32-1:0] m_dat_o,
   input  logic [NUM_MASTERS-1:0]    m_we_i,
   input  logic [NUM_MASTERS-1:0]    m_stb_i,
   input  logic [NUM_MASTERS-1:0]    m_cyc_i,
   output logic [NUM_MASTERS-1:0]    m_ack_o,
   output logic [NUM_MASTERS-1:0]    m_err_o,
   output logic [31:0]               s_adr_o,
   output logic [31:0]               s_dat_o,
   input  logic [31:0]               s_dat_i,
   output logic                      s_we_o,
   output logic                      s_stb_o,
   output logic                      s_cyc_o,
   input  logic                      s_ack_i,
   output logic [NUM_MASTERS-1:0]    grant_o
);

   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);
   localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 state;
   logic [NUM_MASTERS-1:0] grant;
   logic [IW-1:0]          gidx;
   logic [IW-1:0]          last;
   logic [CW-1:0]          tcount;

   logic                   busy;
   logic                   tmo_hit;
   logic                   pick_vld;
   logic [IW-1:0]          pick_idx;

   assign busy    = (state == BUSY);
   assign tmo_hit = (TIMEOUT_CYCLES != 0) && busy && (tcount == TMO_MAX);
   assign grant_o = grant;
   assign m_dat_o = {NUM_MASTERS{s_dat_i}};

   // Scan from farthest to nearest offset so the requester closest after 'last' wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = last;
      for (int off = NUM_MASTERS; off >= 1; off--) begin
         if (m_cyc_i[(int'(last) + off) % NUM_MASTERS]) begin
            pick_vld = 1'b1;
            pick_idx = IW'((int'(last) + off) % NUM_MASTERS);
         end
      end
   end

   always_comb begin
      s_cyc_o = busy;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      if (busy) begin
         s_stb_o       = m_stb_i[gidx] & ~tmo_hit;
         s_we_o        = m_we_i[gidx];
         s_adr_o       = m_adr_i[int'(gidx)*32 +: 32];
         s_dat_o       = m_dat_i[int'(gidx)*32 +: 32];
         m_ack_o[gidx] = s_ack_i & ~tmo_hit;
         m_err_o[gidx] = tmo_hit;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         grant  <= '0;
         gidx   <= '0;
         last   <= LAST_RST;
         tcount <= '0;
      end else begin
         case (state)
            IDLE: begin
               tcount <= '0;
               if (pick_vld) begin
                  state <= BUSY;
                  grant <= ONE_HOT0 << pick_idx;
                  gidx  <= pick_idx;
                  last  <= pick_idx;
               end
            end
            BUSY: begin
               if (tmo_hit || s_ack_i || !m_stb_i[gidx] || TIMEOUT_CYCLES == 0)
                  tcount <= '0;
               else
                  tcount <= tcount + 1'b1;
               if (!m_cyc_i[gidx]) begin
                  state  <= IDLE;
                  grant  <= '0;
                  tcount <= '0;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: two masters, eight-cycle bus timeout.
module tb_wb_arbiter_rr;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [63:0] m_adr_i, m_dat_i, m_dat_o;
   logic [1:0]  m_we_i, m_stb_i, m_cyc_i, m_ack_o, m_err_o, grant_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;

   int n_tests = 0;
   int n_fail  = 0;

   wb_arbiter_rr #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
      .m_we_i(m_we_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
      .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i),
      .grant_o(grant_o)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      i_rst = 1'b1;
      m_adr_i = '0; m_dat_i = '0; m_we_i = '0; m_stb_i = '0; m_cyc_i = '0;
      s_dat_i = '0; s_ack_i = 1'b0;
      tick(); tick();
      i_rst = 1'b0;
      #1;
      chk("rst_grant", 64'(grant_o), 64'h0);
      chk("rst_scyc", 64'(s_cyc_o), 64'h0);
      chk("rst_sstb", 64'(s_stb_o), 64'h0);
      chk("rst_sadr", 64'(s_adr_o), 64'h0);
      chk("rst_ack", 64'(m_ack_o), 64'h0);
      chk("rst_err", 64'(m_err_o), 64'h0);

      // Single master read, slave acks after two cycles
      m_adr_i[31:0] = 32'h100; m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
      #1;
      chk("t1_scyc_lat0", 64'(s_cyc_o), 64'h0);
      tick();
      chk("t1_grant", 64'(grant_o), 64'h1);
      chk("t1_scyc", 64'(s_cyc_o), 64'h1);
      chk("t1_sstb", 64'(s_stb_o), 64'h1);
      chk("t1_sadr", 64'(s_adr_o), 64'h100);
      chk("t1_noack", 64'(m_ack_o), 64'h0);
      tick();
      s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
      #1;
      chk("t1_ack", 64'(m_ack_o), 64'h1);
      chk("t1_dat0", 64'(m_dat_o[31:0]), 64'hDEADBEEF);
      chk("t1_dat1", 64'(m_dat_o[63:32]), 64'hDEADBEEF);
      chk("t1_err", 64'(m_err_o), 64'h0);
      tick();
      s_ack_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
      tick();
      chk("t1_idle_grant", 64'(grant_o), 64'h0);
      chk("t1_idle_scyc", 64'(s_cyc_o), 64'h0);
      s_ack_i = 1'b1;
      #1;
      chk("t1_late_ack", 64'(m_ack_o), 64'h0);
      s_ack_i = 1'b0;

      // Contention after reset
      i_rst = 1'b1; tick(); i_rst = 1'b0;
      m_adr_i = {32'h2000, 32'h1000};
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      tick();
      chk("t2_grant_m0", 64'(grant_o), 64'h1);
      chk("t2_sadr_m0", 64'(s_adr_o), 64'h1000);
      m_cyc_i = 2'b10; m_stb_i = 2'b10;
      tick();
      chk("t2_gap_grant", 64'(grant_o), 64'h0);
      chk("t2_gap_scyc", 64'(s_cyc_o), 64'h0);
      tick();
      chk("t2_grant_m1", 64'(grant_o), 64'h2);
      chk("t2_sadr_m1", 64'(s_adr_o), 64'h2000);
      m_cyc_i = 2'b00; m_stb_i = 2'b00;
      tick();
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      tick();
      chk("t2_tie_m0", 64'(grant_o), 64'h1);
      m_cyc_i = 2'b00; m_stb_i = 2'b00;
      tick();

      // Burst: M1 holds the grant across three writes while M0 waits
      m_cyc_i = 2'b11; m_stb_i = 2'b10; m_we_i = 2'b10;
      tick();
      for (int i = 0; i < 3; i++) begin
         m_adr_i[63:32] = 32'h10 + 32'(4 * i);
         m_dat_i[63:32] = 32'hA0 + 32'(i);
         s_ack_i = 1'b1;
         #1;
         chk("t3_grant", 64'(grant_o), 64'h2);
         chk("t3_sadr", 64'(s_adr_o), 64'h10 + 64'(4 * i));
         chk("t3_sdat", 64'(s_dat_o), 64'hA0 + 64'(i));
         chk("t3_swe", 64'(s_we_o), 64'h1);
         chk("t3_ack", 64'(m_ack_o), 64'h2);
         tick();
      end
      s_ack_i = 1'b0; m_cyc_i = 2'b01; m_stb_i = 2'b00; m_we_i = 2'b00;
      tick();
      chk("t3_rel_grant", 64'(grant_o), 64'h0);
      tick();
      chk("t3_m0_next", 64'(grant_o), 64'h1);
      m_cyc_i = 2'b00;
      tick();

      // Timeout: slave never acks
      m_adr_i[31:0] = 32'h300; m_cyc_i = 2'b01; m_stb_i = 2'b01;
      tick();
      for (int i = 1; i <= 8; i++) begin
         chk("t4_stb_hi", 64'(s_stb_o), 64'h1);
         chk("t4_no_err", 64'(m_err_o), 64'h0);
         tick();
      end
      s_ack_i = 1'b1;
      #1;
      chk("t4_err", 64'(m_err_o), 64'h1);
      chk("t4_stb_lo", 64'(s_stb_o), 64'h0);
      chk("t4_ack_dropped", 64'(m_ack_o), 64'h0);
      tick();
      s_ack_i = 1'b0;
      #1;
      chk("t4_err_once", 64'(m_err_o), 64'h0);
      chk("t4_stb_again", 64'(s_stb_o), 64'h1);
      chk("t4_grant_kept", 64'(grant_o), 64'h1);

      // Reset while busy with stb high
      i_rst = 1'b1; m_cyc_i = 2'b11; m_stb_i = 2'b11;
      tick();
      chk("t5_scyc", 64'(s_cyc_o), 64'h0);
      chk("t5_sstb", 64'(s_stb_o), 64'h0);
      chk("t5_sadr", 64'(s_adr_o), 64'h0);
      chk("t5_grant", 64'(grant_o), 64'h0);
      chk("t5_err", 64'(m_err_o), 64'h0);
      i_rst = 1'b0;
      tick();
      chk("t5_tie_m0", 64'(grant_o), 64'h1);
      m_cyc_i = 2'b00; m_stb_i = 2'b00;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
